// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Holds the FSM state encoding, default parameters and a sizing helper.
package uart_tx_arbiter_pkg;

    // Sequencer states. The encoding values are fixed so that
    // waveforms and debug dumps read the same across builds.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ       = 2;
    localparam int unsigned DEF_START_TIMEOUT = 16;
    localparam int unsigned DEF_CNT_W         = 16;

    // Index width for a set of n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports: i_req request vector, i_ptr search start index;
//        o_grant one-hot winner, o_idx winner index, o_any any request.
module uart_tx_arbiter_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N  = DEF_NUM_REQ,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Extra bit so ptr+k cannot overflow before the modulo fold.
    localparam logic [IW:0] NV = (IW+1)'(N);

    logic [IW:0] w_pos;

    // Walk the requesters starting at i_ptr; the first hit wins.
    // N need not be a power of two, so the wrap is an explicit fold.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_pos >= NV) begin
                w_pos = w_pos - NV;
            end
            if (!o_any && i_req[w_pos[IW-1:0]]) begin
                o_any                   = 1'b1;
                o_grant[w_pos[IW-1:0]] = 1'b1;
                o_idx                   = w_pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a single UART transmitter.
// Ports: clk/rst (sync, active-low); req_valid/req_byte/req_last/req_ready
//        per-requester byte streams; transmit/tx_byte/is_transmitting to the
//        UART; grant_id/locked/busy/tx_error/bytes_sent status.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ       = DEF_NUM_REQ,
    parameter  int unsigned START_TIMEOUT = DEF_START_TIMEOUT,
    parameter  int unsigned CNT_W         = DEF_CNT_W,
    localparam int unsigned GW            = idx_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    input  logic                 is_transmitting,
    output logic [GW-1:0]        grant_id,
    output logic                 locked,
    output logic                 busy,
    output logic                 tx_error,
    output logic [CNT_W-1:0]     bytes_sent
);

    localparam int unsigned TW = idx_w(START_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(NUM_REQ - 1);

    arb_state_t       r_state;
    logic             r_transmit;
    logic [7:0]       r_tx_byte;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    r_rr_ptr;
    logic             r_locked;
    logic             r_tx_error;
    logic [CNT_W-1:0] r_bytes_sent;
    logic [TW-1:0]    r_timer;

    logic [7:0]         w_bytes [NUM_REQ];
    logic [NUM_REQ-1:0] w_pick_grant;
    logic [GW-1:0]      w_pick_idx;
    logic               w_pick_any;
    logic [GW-1:0]      w_win_idx;
    logic               w_win_ok;
    logic [NUM_REQ-1:0] w_ready;
    logic [GW-1:0]      w_next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_bytes[g] = req_byte[8*g +: 8];
    end

    uart_tx_arbiter_rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // While a packet is open, r_grant_id doubles as the owner and the
    // picker result is ignored; no other requester can slip in.
    always_comb begin
        w_win_idx = r_locked ? r_grant_id : w_pick_idx;
        w_win_ok  = 1'b0;
        w_ready   = '0;
        if (r_state == ST_IDLE && !is_transmitting) begin
            if (r_locked) begin
                w_win_ok = req_valid[r_grant_id];
                w_ready[r_grant_id] = req_valid[r_grant_id];
            end else begin
                w_win_ok = w_pick_any;
                w_ready  = w_pick_grant;
            end
        end
    end

    assign w_next_ptr = (w_win_idx == G_LAST) ? '0 : w_win_idx + GW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_transmit   <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
            r_locked     <= 1'b0;
            r_tx_error   <= 1'b0;
            r_bytes_sent <= '0;
            r_timer      <= '0;
        end else begin
            r_transmit <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_win_ok) begin
                        r_tx_byte  <= w_bytes[w_win_idx];
                        r_grant_id <= w_win_idx;
                        r_transmit <= 1'b1;
                        r_state    <= ST_ISSUE;
                        if (req_last[w_win_idx]) begin
                            r_locked <= 1'b0;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_locked <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_bytes_sent <= r_bytes_sent + CNT_W'(1);
                    r_timer      <= '0;
                    r_state      <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // A UART that never starts costs the byte but not
                    // the packet: lock and pointer stay as accepted.
                    if (is_transmitting) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_timer == T_LAST) begin
                        r_tx_error <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!is_transmitting) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign transmit   = r_transmit;
    assign tx_byte    = r_tx_byte;
    assign grant_id   = r_grant_id;
    assign locked     = r_locked;
    assign busy       = (r_state != ST_IDLE);
    assign tx_error   = r_tx_error;
    assign bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a queue-based arbitration model.
// Directed scenarios followed by randomized multi-requester traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;
    localparam int CW = 4;
    localparam int GW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_byte = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic             transmit;
    logic [7:0]       tx_byte;
    logic             is_transmitting = 1'b0;
    logic [GW-1:0]    grant_id;
    logic             locked;
    logic             busy;
    logic             tx_error;
    logic [CW-1:0]    bytes_sent;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO),
        .CNT_W         (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_byte        (req_byte),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .grant_id        (grant_id),
        .locked          (locked),
        .busy            (busy),
        .tx_error        (tx_error),
        .bytes_sent      (bytes_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester packet stores
    logic [7:0] pk_byte [N][256];
    logic       pk_last [N][256];
    int         head [N];
    int         tail [N];
    int         gap [N];
    int         gap_next [N];
    bit         rnd_gap = 0;
    logic [N-1:0] acc_r = '0;

    // Reference model
    bit         m_locked = 0;
    int         m_owner = 0;
    int         m_ptr = 0;
    int         m_gid = 0;
    int         m_sent = 0;
    int         n_tx = 0;
    logic [7:0] exp_q [$];
    logic [7:0] tx_log [$];

    // UART model controls
    bit u_on = 1;
    bit u_rand = 0;

    int cyc = 0;
    int last_tx = 0;
    bit have_prev = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        int j;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (head[i] != tail[i]) return 0;
        return 1;
    endfunction

    task automatic enq(input int r, input logic [7:0] b, input bit last);
        pk_byte[r][tail[r]] = b;
        pk_last[r][tail[r]] = last;
        tail[r]++;
    endtask

    // Requester drivers
    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; gap[i] = 0; gap_next[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_r[i]) begin
                    head[i]++;
                    gap[i] = gap_next[i];
                    gap_next[i] = rnd_gap ? int'($urandom_range(0, 3)) : 0;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end
                if (head[i] < tail[i] && gap[i] == 0) begin
                    req_valid[i] = 1'b1;
                    req_byte[8*i +: 8] = pk_byte[i][head[i]];
                    req_last[i] = pk_last[i][head[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_byte[8*i +: 8] = 8'($urandom);
                    req_last[i] = 1'($urandom);
                end
            end
        end
    end

    // Arbitration checker: predicts the winner and feeds the scoreboard
    initial begin
        int w, a;
        logic [N-1:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                acc_r = '0;
            end else begin
                chk("locked", longint'(locked), longint'(m_locked));
                chk("grant_id", longint'(grant_id), longint'(m_gid));
                if (is_transmitting) begin
                    chk("ready_gated", longint'(req_ready), 0);
                end else if (req_ready != '0) begin
                    w = model_pick(req_valid);
                    e = '0;
                    if (w >= 0) e[w] = 1'b1;
                    chk("winner", longint'(req_ready), longint'(e));
                end
                acc_r = req_ready & req_valid;
                if (acc_r != '0) begin
                    a = 0;
                    for (int i = N - 1; i >= 0; i--)
                        if (acc_r[i]) a = i;
                    exp_q.push_back(pk_byte[a][head[a]]);
                    m_gid = a;
                    if (pk_last[a][head[a]]) begin
                        m_locked = 0;
                        m_ptr = (a + 1) % N;
                    end else begin
                        m_locked = 1;
                        m_owner = a;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every transmit pulse
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1 && transmit === 1'b1) begin
                tx_log.push_back(tx_byte);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_transmit actual=%0h required=none",
                             tx_byte);
                end else begin
                    chk("tx_byte", longint'(tx_byte),
                        longint'(exp_q.pop_front()));
                end
                chk("bytes_sent", longint'(bytes_sent), longint'(m_sent));
                m_sent = (m_sent + 1) % (1 << CW);
                n_tx++;
                if (have_prev)
                    chk("tx_spacing", longint'(cyc - last_tx >= 4), 1);
                last_tx = cyc;
                have_prev = 1;
            end
        end
    end

    // UART model: busy rises dly cycles after transmit, lasts len cycles
    initial begin
        int dly, len;
        forever begin
            @(negedge clk);
            if (transmit === 1'b1 && u_on && rst === 1'b1) begin
                dly = u_rand ? int'($urandom_range(1, 3)) : 1;
                len = u_rand ? int'($urandom_range(1, 20)) : 20;
                repeat (dly) @(posedge clk);
                #1 is_transmitting = 1'b1;
                repeat (len) @(posedge clk);
                #1 is_transmitting = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b0;
        m_locked = 0; m_owner = 0; m_ptr = 0; m_gid = 0;
        m_sent = 0; n_tx = 0;
        exp_q.delete();
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, "_transmit"}, longint'(transmit), 0);
        chk({t, "_tx_byte"}, longint'(tx_byte), 0);
        chk({t, "_req_ready"}, longint'(req_ready), 0);
        chk({t, "_grant_id"}, longint'(grant_id), 0);
        chk({t, "_locked"}, longint'(locked), 0);
        chk({t, "_busy"}, longint'(busy), 0);
        chk({t, "_tx_error"}, longint'(tx_error), 0);
        chk({t, "_bytes_sent"}, longint'(bytes_sent), 0);
    endtask

    task automatic wait_drain(input string t, input int bound);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
            done = all_empty() && !busy && !is_transmitting
                   && exp_q.size() == 0;
        end
        chk({t, "_drain"}, longint'(done), 1);
    endtask

    task automatic wait_tx(input string t, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (transmit !== 1'b1 && n < bound);
        chk({t, "_tx_seen"}, longint'(transmit), 1);
    endtask

    initial begin
        int n, r, len;
        do_reset(3);
        check_reset_vals("por");

        // Single 3-byte packet from requester 0
        tx_log.delete();
        enq(0, 8'h41, 0); enq(0, 8'h42, 0); enq(0, 8'h43, 1);
        wait_drain("t1", 400);
        chk("t1_bytes_sent", longint'(bytes_sent), 3);
        chk("t1_locked", longint'(locked), 0);
        chk("t1_count", tx_log.size(), 3);

        // Two requesters contending with single-byte packets
        do_reset(1);
        tx_log.delete();
        for (int k = 0; k < 4; k++) begin
            enq(0, 8'hA0, 1);
            enq(1, 8'hB0, 1);
        end
        wait_drain("t2", 1000);
        chk("t2_count", tx_log.size(), 8);
        for (int k = 0; k < 8 && k < tx_log.size(); k++)
            chk("t2_order", longint'(tx_log[k]), (k % 2) ? 'hB0 : 'hA0);

        // Owner stalls mid-packet; the other requester must wait
        tx_log.delete();
        gap_next[0] = 30;
        enq(0, 8'h10, 0); enq(0, 8'h11, 1);
        enq(1, 8'hC1, 1); enq(1, 8'hC2, 1);
        repeat (15) @(negedge clk);
        chk("t3_locked_gap", longint'(locked), 1);
        chk("t3_owner", longint'(grant_id), 0);
        chk("t3_no_ready", longint'(req_ready), 0);
        wait_drain("t3", 1000);
        chk("t3_count", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk("t3_b0", longint'(tx_log[0]), 'h10);
            chk("t3_b1", longint'(tx_log[1]), 'h11);
            chk("t3_b2", longint'(tx_log[2]), 'hC1);
        end

        // UART never starts: start timeout
        u_on = 0;
        tx_log.delete();
        enq(1, 8'h5A, 1);
        wait_tx("t4", 200);
        n = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 100);
        chk("t4_wait_cycles", n, TO);
        chk("t4_tx_error", longint'(tx_error), 1);
        u_on = 1;
        enq(0, 8'h77, 1);
        wait_drain("t4", 400);
        chk("t4_error_sticky", longint'(tx_error), 1);
        chk("t4_next_served", tx_log.size(), 2);

        // Reset while the UART frame is still in flight
        enq(0, 8'h99, 1);
        wait_tx("t5", 200);
        enq(1, 8'h55, 1);
        n = 0;
        while (!is_transmitting && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("t5_in_wait_done", longint'(busy && is_transmitting), 1);
        do_reset(1);
        check_reset_vals("mid");
        chk("t5_uart_still_busy", longint'(is_transmitting), 1);
        n = 0;
        while (is_transmitting && n < 50) begin
            chk("t5_no_ready", longint'(req_ready), 0);
            @(negedge clk);
            n++;
        end
        tx_log.delete();
        wait_drain("t5", 400);
        chk("t5_resumed", tx_log.size(), 1);

        // Randomized traffic; bytes_sent wraps several times
        u_rand = 1;
        rnd_gap = 1;
        for (int p = 0; p < 30; p++) begin
            r = int'($urandom_range(0, N - 1));
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++)
                enq(r, 8'($urandom), b == len - 1);
        end
        wait_drain("t6", 20000);
        chk("t6_wrap", longint'(bytes_sent), n_tx % (1 << CW));
        chk("t6_unlocked", longint'(locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
